// File: rtl/left_norm_shifter.sv
// Sequential left-normalizing barrel shifter: strips leading zeros one barrel
// level per clock (largest first) and reports the shift applied.
module left_norm_shifter #(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] Data_i,
    input  logic           bit_shift_i,
    output logic           ready_o,
    output logic           done_o,
    output logic [SWR-1:0] Data_o,
    output logic [EWR-1:0] Shift_Count_o,
    output logic           Zero_o
);

    localparam int LW = (EWR > 1) ? $clog2(EWR) : 1;
    localparam logic [SWR-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [SWR-1:0] work_q, work_d;
    logic [EWR-1:0] count_q, count_d;
    logic [LW-1:0]  level_q, level_d;
    logic           fill_q, fill_d;
    logic [SWR-1:0] data_q, data_d;
    logic [EWR-1:0] shcnt_q, shcnt_d;
    logic           zero_q, zero_d;

    int             amt;
    logic [SWR-1:0] top_mask;
    logic [SWR-1:0] fill_mask;
    logic           step_hit;
    logic [SWR-1:0] step_data;
    logic [EWR-1:0] count_bit;
    logic [EWR-1:0] step_count;

    // Levels wider than the significand can never shift, so they are skipped.
    always_comb begin
        amt        = 1 << level_q;
        top_mask   = '0;
        fill_mask  = '0;
        step_hit   = 1'b0;
        step_data  = work_q;
        count_bit  = EWR'(1) << level_q;
        if (amt < SWR) begin
            top_mask = ~(ONES >> amt);
            if (fill_q) begin
                fill_mask = ~(ONES << amt);
            end
            step_hit = ((work_q & top_mask) == '0);
            if (step_hit) begin
                step_data = (work_q << amt) | fill_mask;
            end
        end
        step_count = step_hit ? (count_q | count_bit) : count_q;
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        level_d = level_q;
        fill_d  = fill_q;
        data_d  = data_q;
        shcnt_d = shcnt_q;
        zero_d  = zero_q;
        ready_o = 1'b0;
        done_o  = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    work_d  = Data_i;
                    fill_d  = bit_shift_i;
                    count_d = '0;
                    level_d = LW'(EWR - 1);
                    if (Data_i == '0) begin
                        zero_d  = 1'b1;
                        data_d  = '0;
                        shcnt_d = '0;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                work_d  = step_data;
                count_d = step_count;
                // Results are captured on the same edge that enters DONE.
                if (level_q == '0) begin
                    data_d  = step_data;
                    shcnt_d = step_count;
                    state_d = DONE;
                end else begin
                    level_d = level_q - LW'(1);
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            level_q <= '0;
            fill_q  <= 1'b0;
            data_q  <= '0;
            shcnt_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            level_q <= level_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            shcnt_q <= shcnt_d;
            zero_q  <= zero_d;
        end
    end

    assign Data_o        = data_q;
    assign Shift_Count_o = shcnt_q;
    assign Zero_o        = zero_q;

endmodule

// File: tb/tb_left_norm_shifter.sv
// Directed bench for left_norm_shifter: hand-computed vectors covering latency,
// fill bit, zero input, busy rejection, back-to-back and reset abort.
module tb_left_norm_shifter;

    localparam int SWR = 26;
    localparam int EWR = 5;

    logic           clk;
    logic           rst;
    logic           start_i;
    logic [SWR-1:0] Data_i;
    logic           bit_shift_i;
    logic           ready_o;
    logic           done_o;
    logic [SWR-1:0] Data_o;
    logic [EWR-1:0] Shift_Count_o;
    logic           Zero_o;

    int vectors;
    int miscompares;

    left_norm_shifter #(.SWR(SWR), .EWR(EWR)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .Data_i        (Data_i),
        .bit_shift_i   (bit_shift_i),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .Data_o        (Data_o),
        .Shift_Count_o (Shift_Count_o),
        .Zero_o        (Zero_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Waits for done_o after the accepting edge; returns cycles counted from that edge.
    task automatic waitDone(output int cycles);
        cycles = 1;
        while (!done_o && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [SWR-1:0] data,
                                 input logic fill, input logic [SWR-1:0] exp_data,
                                 input int exp_count, input logic exp_zero,
                                 input int exp_latency);
        int n;
        int cycles;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) checkOutput({tag, "_ready_timeout"}, 32'(ready_o), 32'd1);
        @(negedge clk);
        start_i     = 1'b1;
        Data_i      = data;
        bit_shift_i = fill;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        Data_i  = '0;
        checkOutput({tag, "_busy"}, 32'(ready_o), 32'd0);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_latency));
        checkOutput({tag, "_done"}, 32'(done_o), 32'd1);
        checkOutput({tag, "_ready_in_done"}, 32'(ready_o), 32'd0);
        checkOutput({tag, "_data"}, 32'(Data_o), 32'(exp_data));
        checkOutput({tag, "_count"}, 32'(Shift_Count_o), 32'(exp_count));
        checkOutput({tag, "_zero"}, 32'(Zero_o), 32'(exp_zero));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        checkOutput({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        checkOutput({tag, "_data_hold"}, 32'(Data_o), 32'(exp_data));
    endtask

    initial begin
        int cycles;
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst         = 1'b0;
        start_i     = 1'b0;
        Data_i      = '0;
        bit_shift_i = 1'b0;

        #3;
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_data", 32'(Data_o), 32'd0);
        checkOutput("rst_count", 32'(Shift_Count_o), 32'd0);
        checkOutput("rst_zero", 32'(Zero_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus("lsb", 26'h0000001, 1'b0, 26'h2000000, 25, 1'b0, 6);
        applyStimulus("norm", 26'h2000000, 1'b0, 26'h2000000, 0, 1'b0, 6);
        applyStimulus("fill1", 26'h0000F00, 1'b1, 26'h3C03FFF, 14, 1'b0, 6);
        applyStimulus("lsb_fill1", 26'h0000001, 1'b1, 26'h3FFFFFF, 25, 1'b0, 6);
        applyStimulus("mixed", 26'h0ABCDEF, 1'b0, 26'h2AF37BC, 2, 1'b0, 6);
        applyStimulus("zero", 26'h0000000, 1'b1, 26'h0000000, 0, 1'b1, 1);
        applyStimulus("after_zero", 26'h0000100, 1'b0, 26'h2000000, 17, 1'b0, 6);

        // Busy rejection: start stays high with a new operand through the busy period.
        @(negedge clk);
        start_i = 1'b1;
        Data_i  = 26'h0000010;
        @(posedge clk);
        #1;
        Data_i = 26'h1000000;
        waitDone(cycles);
        checkOutput("b2b_first_latency", 32'(cycles), 32'd6);
        checkOutput("b2b_first_data", 32'(Data_o), 32'h2000000);
        checkOutput("b2b_first_count", 32'(Shift_Count_o), 32'd21);
        @(posedge clk);
        #1;
        checkOutput("b2b_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        Data_i  = '0;
        checkOutput("b2b_second_busy", 32'(ready_o), 32'd0);
        checkOutput("b2b_hold_count", 32'(Shift_Count_o), 32'd21);
        waitDone(cycles);
        checkOutput("b2b_second_latency", 32'(cycles), 32'd6);
        checkOutput("b2b_second_data", 32'(Data_o), 32'h2000000);
        checkOutput("b2b_second_count", 32'(Shift_Count_o), 32'd1);
        @(posedge clk);
        #1;

        // Reset asserted mid-shift aborts without a done pulse.
        @(negedge clk);
        start_i = 1'b1;
        Data_i  = 26'h0000003;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        Data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(ready_o), 32'd1);
        checkOutput("abort_done", 32'(done_o), 32'd0);
        checkOutput("abort_data", 32'(Data_o), 32'd0);
        checkOutput("abort_count", 32'(Shift_Count_o), 32'd0);
        checkOutput("abort_zero", 32'(Zero_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", 32'(done_o), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_abort_no_done", 32'(done_o), 32'd0);
        end
        applyStimulus("post_abort", 26'h0000003, 1'b0, 26'h3000000, 24, 1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
